// File: rtl/bomb_scheduler.sv
// Bomb pool controller: edge-detects drop requests, arbitrates them onto free
// slots and sequences each slot through fuse, explode pulse and blast window.
//
//   state | meaning
//   FREE  | slot idle, may be granted
//   ARMED | fuse counting down, chain_hit honored
//   BLAST | blast window counting down, slot returns to pool at zero
module bomb_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_FRAMES    = 120,
    parameter int BLAST_FRAMES   = 30
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 p1_drop,
    input  logic                 p2_drop,
    input  logic [9:0]           p1X,
    input  logic [9:0]           p1Y,
    input  logic [9:0]           p2X,
    input  logic [9:0]           p2Y,
    input  logic [NUM_SLOTS-1:0] chain_hit,
    output logic [NUM_SLOTS-1:0] slot_make,
    output logic [9:0]           drop_x,
    output logic [9:0]           drop_y,
    output logic [NUM_SLOTS-1:0] slot_explode,
    output logic [NUM_SLOTS-1:0] blast_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [2:0]           p1_count,
    output logic [2:0]           p2_count,
    output logic                 p1_denied,
    output logic                 p2_denied
);

    localparam int FW = $clog2(FUSE_FRAMES);
    localparam int BW = $clog2(BLAST_FRAMES + 1);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [FW-1:0] FUSE_LOAD  = FW'(FUSE_FRAMES - 1);
    localparam logic [BW-1:0] BLAST_LOAD = BW'(BLAST_FRAMES - 1);
    localparam logic [2:0]    MAX_CNT    = 3'(MAX_PER_PLAYER);

    typedef enum logic [1:0] {FREE, ARMED, BLAST} slot_state_t;

    slot_state_t         state   [NUM_SLOTS];
    slot_state_t         state_n [NUM_SLOTS];
    logic [FW-1:0]       fuse_cnt   [NUM_SLOTS];
    logic [FW-1:0]       fuse_cnt_n [NUM_SLOTS];
    logic [BW-1:0]       blast_cnt   [NUM_SLOTS];
    logic [BW-1:0]       blast_cnt_n [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] owner_n, make_n, explode_n;

    logic        p1_prev, p2_prev, p1_pend, p2_pend, rr;
    logic        p1_pend_n, p2_pend_n, rr_n;
    logic        p1_rise, p2_rise, p1_elig, p2_elig;
    logic        grant_p1, grant_p2, grant, contested;
    logic        p1_deny, p2_deny;
    logic        any_free;
    logic [SW-1:0] free_idx;
    logic [2:0]  p1_dec, p2_dec, p1_count_n, p2_count_n;
    logic [9:0]  drop_x_n, drop_y_n;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            blast_active[i] = (state[i] == BLAST);
        end
    end

    always_comb begin
        // lowest-index FREE slot, judged on state at the start of the frame
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == FREE) begin
                any_free = 1'b1;
                free_idx = SW'(i);
            end
        end

        p1_rise = p1_drop & ~p1_prev;
        p2_rise = p2_drop & ~p2_prev;
        p1_elig = p1_pend & (p1_count < MAX_CNT);
        p2_elig = p2_pend & (p2_count < MAX_CNT);

        grant_p1  = 1'b0;
        grant_p2  = 1'b0;
        contested = 1'b0;
        if (any_free) begin
            if (p1_elig && p2_elig) begin
                contested = 1'b1;
                if (rr) grant_p2 = 1'b1;
                else    grant_p1 = 1'b1;
            end else if (p1_elig) begin
                grant_p1 = 1'b1;
            end else if (p2_elig) begin
                grant_p2 = 1'b1;
            end
        end
        grant = grant_p1 | grant_p2;

        p1_deny = (p1_pend & ~p1_elig) | (p1_elig & ~any_free);
        p2_deny = (p2_pend & ~p2_elig) | (p2_elig & ~any_free);

        p1_pend_n = p1_pend ? ~(grant_p1 | p1_deny) : p1_rise;
        p2_pend_n = p2_pend ? ~(grant_p2 | p2_deny) : p2_rise;
        rr_n      = contested ? ~rr : rr;

        drop_x_n = drop_x;
        drop_y_n = drop_y;
        if (grant) begin
            drop_x_n = grant_p2 ? p2X : p1X;
            drop_y_n = grant_p2 ? p2Y : p1Y;
        end

        owner_n   = slot_owner;
        make_n    = '0;
        explode_n = '0;
        p1_dec    = 3'd0;
        p2_dec    = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_n[i]     = state[i];
            fuse_cnt_n[i]  = fuse_cnt[i];
            blast_cnt_n[i] = blast_cnt[i];
            case (state[i])
                FREE: begin
                    if (grant && (free_idx == SW'(i))) begin
                        state_n[i]    = ARMED;
                        fuse_cnt_n[i] = FUSE_LOAD;
                        owner_n[i]    = grant_p2;
                        make_n[i]     = 1'b1;
                    end
                end
                ARMED: begin
                    if ((fuse_cnt[i] == '0) || chain_hit[i]) begin
                        state_n[i]     = BLAST;
                        blast_cnt_n[i] = BLAST_LOAD;
                        explode_n[i]   = 1'b1;
                    end else begin
                        fuse_cnt_n[i] = fuse_cnt[i] - 1'b1;
                    end
                end
                BLAST: begin
                    if (blast_cnt[i] == '0) begin
                        state_n[i] = FREE;
                        if (slot_owner[i]) p2_dec = p2_dec + 3'd1;
                        else               p1_dec = p1_dec + 3'd1;
                    end else begin
                        blast_cnt_n[i] = blast_cnt[i] - 1'b1;
                    end
                end
                default: state_n[i] = FREE;
            endcase
        end

        p1_count_n = p1_count + {2'b00, grant_p1} - p1_dec;
        p2_count_n = p2_count + {2'b00, grant_p2} - p2_dec;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i]     <= FREE;
                fuse_cnt[i]  <= '0;
                blast_cnt[i] <= '0;
            end
            slot_owner   <= '0;
            slot_make    <= '0;
            slot_explode <= '0;
            drop_x       <= '0;
            drop_y       <= '0;
            p1_prev      <= 1'b0;
            p2_prev      <= 1'b0;
            p1_pend      <= 1'b0;
            p2_pend      <= 1'b0;
            rr           <= 1'b0;
            p1_count     <= '0;
            p2_count     <= '0;
            p1_denied    <= 1'b0;
            p2_denied    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i]     <= state_n[i];
                fuse_cnt[i]  <= fuse_cnt_n[i];
                blast_cnt[i] <= blast_cnt_n[i];
            end
            slot_owner   <= owner_n;
            slot_make    <= make_n;
            slot_explode <= explode_n;
            drop_x       <= drop_x_n;
            drop_y       <= drop_y_n;
            p1_prev      <= p1_drop;
            p2_prev      <= p2_drop;
            p1_pend      <= p1_pend_n;
            p2_pend      <= p2_pend_n;
            rr           <= rr_n;
            p1_count     <= p1_count_n;
            p2_count     <= p2_count_n;
            p1_denied    <= p1_deny;
            p2_denied    <= p2_deny;
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: single drop, contention, player limit,
// pool exhaustion, chain detonation and reset mid-blast.
module tb_bomb_scheduler;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       p1_drop, p2_drop;
    logic [9:0] p1X, p1Y, p2X, p2Y;
    logic [3:0] chain_hit;
    logic [3:0] slot_make, slot_explode, blast_active, slot_owner;
    logic [9:0] drop_x, drop_y;
    logic [2:0] p1_count, p2_count;
    logic       p1_denied, p2_denied;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int g0, g1;

    bomb_scheduler #(
        .NUM_SLOTS(4), .MAX_PER_PLAYER(2), .FUSE_FRAMES(120), .BLAST_FRAMES(30)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .p1_drop(p1_drop), .p2_drop(p2_drop),
        .p1X(p1X), .p1Y(p1Y), .p2X(p2X), .p2Y(p2Y),
        .chain_hit(chain_hit),
        .slot_make(slot_make), .drop_x(drop_x), .drop_y(drop_y),
        .slot_explode(slot_explode), .blast_active(blast_active),
        .slot_owner(slot_owner),
        .p1_count(p1_count), .p2_count(p2_count),
        .p1_denied(p1_denied), .p2_denied(p2_denied)
    );

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    // at a negedge, cyc equals the number of the rising edge just passed
    task automatic wait_to(input int t);
        while (cyc < t) @(negedge frame_clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        p1_drop = 1'b0;
        p2_drop = 1'b0;
        chain_hit = 4'b0;
        step(2);
        Reset = 1'b0;
        step(1);
    endtask

    // returns at the negedge right after the grant/deny edge
    task automatic press(input int who);
        if (who == 1) p1_drop = 1'b1;
        else          p2_drop = 1'b1;
        step(2);
        p1_drop = 1'b0;
        p2_drop = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        p1_drop = 1'b0; p2_drop = 1'b0;
        p1X = '0; p1Y = '0; p2X = '0; p2Y = '0;
        chain_hit = 4'b0;
        #1;
        check("rst_make", slot_make, 0);
        check("rst_blast", blast_active, 0);
        check("rst_counts", {p1_count, p2_count}, 0);
        check("rst_dropxy", {drop_x, drop_y}, 0);

        // single drop
        do_reset();
        p1X = 10'd100; p1Y = 10'd60; p1_drop = 1'b1;
        step(1);
        check("s1_make_early", slot_make, 0);
        step(1);
        p1_drop = 1'b0;
        g0 = cyc;
        check("s1_make", slot_make, 4'b0001);
        check("s1_drop_x", drop_x, 100);
        check("s1_drop_y", drop_y, 60);
        check("s1_p1_count", p1_count, 1);
        step(1);
        check("s1_make_pulse", slot_make, 0);
        wait_to(g0 + 119);
        check("s1_explode_early", slot_explode, 0);
        step(1);
        check("s1_explode", slot_explode, 4'b0001);
        check("s1_blast_rise", blast_active, 4'b0001);
        step(1);
        check("s1_explode_pulse", slot_explode, 0);
        wait_to(g0 + 149);
        check("s1_blast_last", blast_active, 4'b0001);
        step(1);
        check("s1_blast_fall", blast_active, 0);
        check("s1_p1_count_end", p1_count, 0);

        // contention, rr toggle, pool exhaustion
        do_reset();
        p1X = 10'd10; p1Y = 10'd20; p2X = 10'd30; p2Y = 10'd40;
        p1_drop = 1'b1; p2_drop = 1'b1;
        step(2);
        g0 = cyc;
        check("s2_make_a", slot_make, 4'b0001);
        check("s2_drop_a", {drop_x, drop_y}, {10'd10, 10'd20});
        step(1);
        check("s2_make_b", slot_make, 4'b0010);
        check("s2_drop_b", {drop_x, drop_y}, {10'd30, 10'd40});
        check("s2_counts_b", {p1_count, p2_count}, {3'd1, 3'd1});
        p1_drop = 1'b0; p2_drop = 1'b0;
        step(1);
        p1X = 10'd70; p1Y = 10'd80; p2X = 10'd50; p2Y = 10'd60;
        p1_drop = 1'b1; p2_drop = 1'b1;
        step(2);
        check("s2_make_c", slot_make, 4'b0100);
        check("s2_drop_c", {drop_x, drop_y}, {10'd50, 10'd60});
        check("s2_owner_c", slot_owner[2:0], 3'b110);
        step(1);
        check("s2_make_d", slot_make, 4'b1000);
        check("s2_drop_d", {drop_x, drop_y}, {10'd70, 10'd80});
        check("s2_counts_d", {p1_count, p2_count}, {3'd2, 3'd2});
        p1_drop = 1'b0; p2_drop = 1'b0;
        step(1);
        press(1);
        check("s2_p1_denied", p1_denied, 1);
        check("s2_full_make", slot_make, 0);
        check("s2_full_count", p1_count, 2);
        step(1);
        check("s2_denied_pulse", p1_denied, 0);
        wait_to(g0 + 149);
        check("s2_blast0", blast_active[0], 1);
        p1X = 10'd200; p1Y = 10'd300;
        p1_drop = 1'b1; p2_drop = 1'b1;
        step(1);
        check("s2_slot0_freed", blast_active[0], 0);
        check("s2_p1_dec", p1_count, 1);
        check("s2_make_none", slot_make, 0);
        step(1);
        p1_drop = 1'b0; p2_drop = 1'b0;
        check("s2_p2_denied", p2_denied, 1);
        check("s2_p1_not_denied", p1_denied, 0);
        check("s2_regrant", slot_make, 4'b0001);
        check("s2_regrant_xy", {drop_x, drop_y}, {10'd200, 10'd300});
        check("s2_counts_end", {p1_count, p2_count}, {3'd2, 3'd1});

        // player limit
        do_reset();
        p1X = 10'd5; p1Y = 10'd6;
        press(1);
        check("s3_make0", slot_make, 4'b0001);
        step(3);
        press(1);
        check("s3_make1", slot_make, 4'b0010);
        check("s3_count2", p1_count, 2);
        step(3);
        press(1);
        check("s3_denied", p1_denied, 1);
        check("s3_no_make", slot_make, 0);
        check("s3_count_hold", p1_count, 2);
        step(1);
        check("s3_denied_pulse", p1_denied, 0);

        // chain detonation
        do_reset();
        press(1);
        step(3);
        press(1);
        g1 = cyc;
        check("s4_make1", slot_make, 4'b0010);
        wait_to(g1 + 70);
        chain_hit = 4'b0110;
        check("s4_explode_pre", slot_explode, 0);
        step(1);
        chain_hit = 4'b0000;
        check("s4_chain_explode", slot_explode, 4'b0010);
        check("s4_chain_blast", blast_active, 4'b0010);
        step(1);
        check("s4_explode_pulse", slot_explode, 0);
        check("s4_free_ignored", slot_make, 0);
        wait_to(g1 + 100);
        check("s4_blast_last", blast_active, 4'b0010);
        step(1);
        check("s4_blast_fall", blast_active, 0);
        check("s4_count", p1_count, 1);

        // reset mid-blast
        do_reset();
        p2X = 10'd300; p2Y = 10'd400;
        press(1);
        step(3);
        press(2);
        g1 = cyc;
        check("s5_owner1", slot_owner[1:0], 2'b10);
        wait_to(g1 + 125);
        check("s5_both_blast", blast_active, 4'b0011);
        #2 Reset = 1'b1;
        #1;
        check("s5_rst_blast", blast_active, 0);
        check("s5_rst_explode", slot_explode, 0);
        check("s5_rst_counts", {p1_count, p2_count}, 0);
        check("s5_rst_owner", slot_owner, 0);
        check("s5_rst_dropxy", {drop_x, drop_y}, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(1);
        check("s5_no_explode", slot_explode, 0);
        p2X = 10'd11; p2Y = 10'd22;
        press(2);
        check("s5_regrant", slot_make, 4'b0001);
        check("s5_owner", slot_owner[0], 1);
        check("s5_p2_count", p2_count, 1);
        check("s5_drop", {drop_x, drop_y}, {10'd11, 10'd22});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bomb_scheduler.md
# bomb_scheduler

Lifecycle controller and slot arbiter for the pool of `bomb` instances. It takes drop requests from two players and assigns each granted request to a free bomb slot. For every slot it sequences the fuse countdown, the explode pulse and the blast window, then returns the slot to the pool. It sits between the player movement/keyboard logic and the `bomb` instances, driving their `make`, `explode` and `userX`/`userY` inputs, all on `frame_clk`.

## Interface
- `NUM_SLOTS`, 4: number of bomb instances managed (2..8).
- `MAX_PER_PLAYER`, 2: maximum slots one player may own at once.
- `FUSE_FRAMES`, 120: frames from grant to explode pulse (≥2).
- `BLAST_FRAMES`, 30: frames `blast_active` stays high after explode (≥1).
- `frame_clk` in 1: frame-rate clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-high.
- `p1_drop`, `p2_drop` in 1: drop buttons, level; rising edge = one request.
- `p1X`, `p1Y`, `p2X`, `p2Y` in 10 each: player positions, sampled at grant.
- `chain_hit` in NUM_SLOTS: per-slot early detonation (blast overlap); honored only in ARMED.
- `slot_make` out NUM_SLOTS: one-hot, one-frame pulse to the granted slot's `make`.
- `drop_x`, `drop_y` out 10 each: shared coordinate bus to all slots' `userX`/`userY`; valid whenever `slot_make` ≠ 0.
- `slot_explode` out NUM_SLOTS: one-frame pulse to a slot's `explode`.
- `blast_active` out NUM_SLOTS: high during that slot's BLAST state.
- `slot_owner` out NUM_SLOTS: 0 = P1, 1 = P2; meaningful only when the slot is not FREE.
- `p1_count`, `p2_count` out 3 each: slots currently owned per player.
- `p1_denied`, `p2_denied` out 1: one-frame pulse when a pending request is discarded.

## Operation
- Edge detect: register `pN_drop`. A rising edge sets `pN_pend`. Further edges while pending are ignored (no queueing beyond one).
- Per-slot FSM, states FREE, ARMED, BLAST:
  - FREE→ARMED on grant: load `fuse_cnt = FUSE_FRAMES-1`, latch owner.
  - ARMED: decrement `fuse_cnt` each frame. When `fuse_cnt == 0` or `chain_hit[i]` is set, go to BLAST, load `blast_cnt = BLAST_FRAMES-1`, and pulse `slot_explode[i]` in that same transition frame.
  - BLAST: decrement `blast_cnt`. When it reaches 0, go to FREE and decrement the owner's count.
  - `chain_hit` in FREE or BLAST is ignored.
- Grant, evaluated once per frame:
  - A player is eligible if pending and `count < MAX_PER_PLAYER`.
  - The free slot chosen is the lowest-index FREE slot at the start of the frame.
  - At most one grant per frame.
  - If both players are eligible, the round-robin pointer `rr` picks the winner (0 = P1 first). `rr` toggles after every contested grant only. The loser stays pending.
- Denial:
  - A pending player at `MAX_PER_PLAYER` is cleared with a `denied` pulse.
  - A pending player that is eligible while no slot is FREE is cleared with a `denied` pulse.
  - The arbitration loser is not denied in the frame it loses.
- A slot freed in frame n is grantable from frame n+1, never in the same frame.
- Counts: increment on grant, decrement on BLAST→FREE. The same player may do both in one frame, leaving the count unchanged.

## Timing
- Reset (async): all slots FREE, all counters 0, `rr`=0, pend=0. `slot_make`, `slot_explode`, `blast_active`, `slot_owner`, counts and denied are all 0. `drop_x`/`drop_y` are 0.
- Drop latency:
  - The rising edge of `pN_drop` is sampled at edge k, so pending is set at k.
  - The grant happens at edge k+1: `slot_make` is high and `drop_x`/`drop_y` hold the granted player's coordinates during frame k+1..k+2.
  - The slot enters ARMED at edge k+1.
- Explode: `slot_explode` is high exactly FUSE_FRAMES frames after `slot_make` rose, unless `chain_hit` forces it earlier (at the edge following the `chain_hit` sample).
- `blast_active` rises with `slot_explode` and stays high BLAST_FRAMES frames. The slot is FREE the edge after `blast_active` falls.
- All outputs are registered. No combinational input→output paths.
- Reset mid-operation aborts every slot with no `explode` pulse. The `bomb` instances share `Reset` and clear themselves.

## Test plan
- Single drop: reset, then P1 at (100,60) presses once → `slot_make`=0001 one frame later with `drop_x`=100, `drop_y`=60. `slot_explode[0]` pulses 120 frames after `make`. `blast_active[0]` is high 30 frames. Slot 0 is FREE and `p1_count`=0 afterwards.
- Contention: both players press in the same frame with 4 slots free → P1 gets slot 0 on frame k+1 and P2 gets slot 1 on frame k+2. The next contested pair grants P2 first (`rr` toggled).
- Player limit: P1 presses three times 5 frames apart → slots 0 and 1 granted, third press gives a `p1_denied` pulse, `p1_count`=2.
- Pool exhaustion: 4 slots filled (2 per player), then P1 presses → `p1_denied`. After slot 0 frees, a P2 press is denied (P2 still at limit) and a P1 press is granted slot 0.
- Chain: slot 1 ARMED with 50 frames of fuse left, assert `chain_hit[1]` for one frame → `slot_explode[1]` on the next frame. `chain_hit[2]` asserted while slot 2 is FREE → no effect.
- Reset mid-blast: assert `Reset` while slots 0 and 1 are in BLAST → all outputs 0 immediately, counts 0. A press after release is granted slot 0.
